// File: rtl/debug_pkg.sv
// Shared definitions for the debug frame serializer: defaults, FSM encoding,
// and the byte-count helper used to size the frame.
package debug_pkg;

    localparam int          DEFAULT_DATA_W   = 1720;
    localparam logic [7:0]  DEFAULT_SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bytes needed to hold a width-bit payload, rounding a partial byte up.
    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/debug_xor_accum.sv
// Running XOR of the payload bytes, appended as a trailing check byte.
// Only built when DBG_TX_CHECKSUM_EN is defined.
`ifdef DBG_TX_CHECKSUM_EN
module debug_xor_accum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (clear) begin
            sum_q <= 8'h00;
        end else if (en) begin
            sum_q <= sum_q ^ din;
        end
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/debug_frame_serializer.sv
// Captures a wide debug snapshot and streams it as SOF + MSB-first payload
// bytes into the UART TX FIFO. Define DBG_TX_CHECKSUM_EN to append an XOR byte.
module debug_frame_serializer
    import debug_pkg::*;
#(
    parameter int         DATA_W   = DEFAULT_DATA_W,
    parameter logic [7:0] SOF_BYTE = DEFAULT_SOF_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_signal,
    input  logic [DATA_W-1:0] send_data,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              data_sent
);

    localparam int NB = nbytes(DATA_W);
`ifdef DBG_TX_CHECKSUM_EN
    localparam int FRAME = NB + 2;
`else
    localparam int FRAME = NB + 1;
`endif
    localparam int SR_W  = 8 * (NB + 1);
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d, sr_load;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept_req;
    logic              byte_taken;
    logic [7:0]        head_byte;

    assign accept_req = (state_q == IDLE) && send_signal;
    assign byte_taken = (state_q == SEND) && !tx_full;
    assign head_byte  = sr_q[SR_W-1 -: 8];

    // SOF in the top byte, payload right below it, pad bits left at zero.
    always_comb begin
        sr_load = '0;
        sr_load[SR_W-1 -: 8]      = SOF_BYTE;
        sr_load[SR_W-9 -: DATA_W] = send_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send_signal) state_d = SEND;
            SEND:    if (byte_taken && (cnt_q == LAST_IDX)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (accept_req) begin
            sr_d  = sr_load;
            cnt_d = '0;
        end else if (byte_taken) begin
            sr_d  = {sr_q[SR_W-9:0], 8'h00};
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef DBG_TX_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_en;

    // Payload bytes occupy frame slots 1..NB; slot 0 is SOF.
    assign csum_en = byte_taken && (cnt_q != '0) && (cnt_q <= CNT_W'(NB));

    debug_xor_accum u_xor_accum (
        .clk   (clk),
        .reset (reset),
        .clear (accept_req),
        .en    (csum_en),
        .din   (head_byte),
        .sum   (csum)
    );
`endif

    always_comb begin
        wr_uart   = byte_taken;
        data_sent = (state_q == DONE);
        w_data    = head_byte;
`ifdef DBG_TX_CHECKSUM_EN
        if ((state_q == SEND) && (cnt_q == LAST_IDX)) w_data = csum;
`endif
    end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Directed bench for debug_frame_serializer: four widths (16, 12, 1720, 1)
// share one clock and reset; DBG_TX_CHECKSUM_EN adds the trailing XOR byte.
module tb_debug_frame_serializer;

  logic          clk = 1'b0;
  logic          reset;
  logic          send_i [4];
  logic          full_i [4];
  logic [3:0]    wr_o;
  logic [3:0]    ds_o;
  logic [7:0]    wd_o [4];
  logic [15:0]   d16;
  logic [11:0]   d12;
  logic [1719:0] dbig;
  logic [0:0]    d1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  debug_frame_serializer #(.DATA_W(16)) u16 (
    .clk(clk), .reset(reset), .send_signal(send_i[0]), .send_data(d16),
    .tx_full(full_i[0]), .wr_uart(wr_o[0]), .w_data(wd_o[0]), .data_sent(ds_o[0]));
  debug_frame_serializer #(.DATA_W(12)) u12 (
    .clk(clk), .reset(reset), .send_signal(send_i[1]), .send_data(d12),
    .tx_full(full_i[1]), .wr_uart(wr_o[1]), .w_data(wd_o[1]), .data_sent(ds_o[1]));
  debug_frame_serializer #(.DATA_W(1720)) ubig (
    .clk(clk), .reset(reset), .send_signal(send_i[2]), .send_data(dbig),
    .tx_full(full_i[2]), .wr_uart(wr_o[2]), .w_data(wd_o[2]), .data_sent(ds_o[2]));
  debug_frame_serializer #(.DATA_W(1)) u1 (
    .clk(clk), .reset(reset), .send_signal(send_i[3]), .send_data(d1),
    .tx_full(full_i[3]), .wr_uart(wr_o[3]), .w_data(wd_o[3]), .data_sent(ds_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Raise send_signal for the cycle whose closing edge is "edge 0".
  task automatic request(input int s);
    @(posedge clk); #1;
    send_i[s] = 1'b1;
  endtask

  // mode 0: no backpressure, 1: tx_full on odd cycles, 2: re-request and
  // change data during the frame, 3: tx_full held for cycles 1..5.
  task automatic collect(input int s, input int budget, input int mode);
    int  nexp;
    int  first_wr;
    int  ds_c;
    bit  got;
    logic [7:0] eb;
    nexp = exp_q.size();
    first_wr = -1;
    ds_c = -1;
    got = 1'b0;
    for (int c = 1; c <= budget && !got; c++) begin
      @(posedge clk); #1;
      send_i[s] = (mode == 2);
      if (mode == 2 && c == 2) d16 = 16'h0000;
      full_i[s] = (mode == 1) ? c[0] : (mode == 3) ? (c <= 5) : 1'b0;
      @(negedge clk);
      if (mode == 3 && c <= 5) chk("hold_no_wr", {31'd0, wr_o[s]}, 32'd0);
      if (wr_o[s]) begin
        if (first_wr < 0) first_wr = c;
        chk("byte_expected", exp_q.size() > 0, 32'd1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          chk($sformatf("frame%0d_byte_c%0d", s, c), {24'd0, wd_o[s]}, {24'd0, eb});
        end
      end
      if (ds_o[s]) begin
        got = 1'b1;
        ds_c = c;
        chk("ds_without_wr", {31'd0, wr_o[s]}, 32'd0);
        chk("ds_after_all_bytes", exp_q.size(), 32'd0);
      end
    end
    chk("frame_done_in_budget", {31'd0, got}, 32'd1);
    case (mode)
      1: begin
        chk("first_wr_cycle", first_wr, 32'd2);
        chk("ds_cycle", ds_c, 2 * nexp + 1);
      end
      3: begin
        chk("first_wr_cycle", first_wr, 32'd6);
        chk("ds_cycle", ds_c, nexp + 6);
      end
      default: begin
        chk("first_wr_cycle", first_wr, 32'd1);
        chk("ds_cycle", ds_c, nexp + 1);
      end
    endcase
    send_i[s] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      send_i[s] = 1'b0;
      full_i[s] = 1'b0;
      @(negedge clk);
      chk("quiet_ds", {31'd0, ds_o[s]}, 32'd0);
      chk("quiet_wr", {31'd0, wr_o[s]}, 32'd0);
    end
  endtask

  task automatic load_big_exp();
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 215; k++) begin
      b = dbig[1719 - 8 * k -: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_i[i] = 1'b0;
      full_i[i] = 1'b0;
    end
    d16 = '0; d12 = '0; dbig = '0; d1 = '0;

    // Reset state on every instance
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_wr", {31'd0, wr_o[i]}, 32'd0);
      chk("reset_wdata", {24'd0, wd_o[i]}, 32'd0);
      chk("reset_ds", {31'd0, ds_o[i]}, 32'd0);
    end

    // 16'hBEEF, no backpressure
    d16 = 16'hBEEF;
    exp_q = '{8'hA5, 8'hBE, 8'hEF};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h51);
`endif
    request(0);
    collect(0, 20, 0);

    // 12-bit payload with LSB zero pad
    d12 = 12'hABC;
    exp_q = '{8'hA5, 8'hAB, 8'hC0};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h6B);
`endif
    request(1);
    collect(1, 20, 0);

    // tx_full held for cycles 1..5
    d16 = 16'h1234;
    exp_q = '{8'hA5, 8'h12, 8'h34};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h26);
`endif
    request(0);
    full_i[0] = 1'b1;
    collect(0, 30, 3);

    // tx_full toggling every cycle
    d16 = 16'hC35A;
    exp_q = '{8'hA5, 8'hC3, 8'h5A};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h99);
`endif
    request(0);
    collect(0, 30, 1);

    // Re-request and data change during SEND are ignored
    d16 = 16'hBEEF;
    exp_q = '{8'hA5, 8'hBE, 8'hEF};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h51);
`endif
    request(0);
    collect(0, 20, 2);

    // DATA_W = 1
    d1 = 1'b1;
    exp_q = '{8'hA5, 8'h80};
`ifdef DBG_TX_CHECKSUM_EN
    exp_q.push_back(8'h80);
`endif
    request(3);
    collect(3, 20, 0);

    // 1720-bit frame aborted by reset after two bytes, then a full frame
    for (int k = 0; k < 215; k++) dbig[k * 8 +: 8] = 8'($urandom_range(0, 255));
    load_big_exp();
    request(2);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      send_i[2] = 1'b0;
      @(negedge clk);
      chk("big_pre_abort_wr", {31'd0, wr_o[2]}, 32'd1);
      chk("big_pre_abort_byte", {24'd0, wd_o[2]}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_wr", {31'd0, wr_o[2]}, 32'd0);
    chk("abort_wdata", {24'd0, wd_o[2]}, 32'd0);
    chk("abort_ds", {31'd0, ds_o[2]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_abort_ds", {31'd0, ds_o[2]}, 32'd0);
      chk("post_abort_wr", {31'd0, wr_o[2]}, 32'd0);
    end
    load_big_exp();
    request(2);
    collect(2, 400, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
